// File: rtl/inv_sbox_word_sched_if.sv
// Word request/response bundle between the two requesters,
// the result consumer and the shared inverse S-box scheduler.
interface inv_sbox_word_sched_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [31:0] req0_data;
    logic        req1_valid;
    logic        req1_ready;
    logic [31:0] req1_data;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic        resp_id;

    modport master (
        output req0_valid, req0_data,
        output req1_valid, req1_data,
        output resp_ready,
        input  req0_ready, req1_ready,
        input  resp_valid, resp_data, resp_id
    );

    modport slave (
        input  req0_valid, req0_data,
        input  req1_valid, req1_data,
        input  resp_ready,
        output req0_ready, req1_ready,
        output resp_valid, resp_data, resp_id
    );
endinterface

// File: rtl/inv_sbox_word_sched.sv
// Round-robin scheduler sharing one byte-wide inverse S-box
// between two 32-bit word requesters.
module inv_sbox_word_sched #(
    parameter int SBOX_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    inv_sbox_word_sched_if.slave bus,
    output logic [7:0]           sbox_in,
    input  logic [7:0]           sbox_out,
    output logic                 busy
);

    if (SBOX_LAT < 0 || SBOX_LAT > 4) begin : g_lat_check
        $error("inv_sbox_word_sched: SBOX_LAT must be in 0..4");
    end

    typedef enum logic [1:0] {IDLE, FEED, DRAIN, RESP} state_t;

    state_t          state;
    logic            rr;
    logic            id;
    logic [1:0]      cnt;
    logic [23:0]     rest;
    logic [3:0][7:0] res;
    logic            resp_valid;
    logic            gnt0;
    logic            gnt1;
    logic            acc0;
    logic            acc1;
    logic [31:0]     sel_data;
    logic            fed_v;
    logic            cap_v;
    logic [1:0]      cap_i;

    // With both valid, the requester that did not win last time goes.
    assign gnt0     = bus.req0_valid & (~bus.req1_valid | rr);
    assign gnt1     = bus.req1_valid & (~bus.req0_valid | ~rr);
    assign acc0     = (state == IDLE) & gnt0;
    assign acc1     = (state == IDLE) & gnt1;
    assign sel_data = acc1 ? bus.req1_data : bus.req0_data;
    assign fed_v    = (state == FEED);

    assign bus.req0_ready = acc0;
    assign bus.req1_ready = acc1;
    assign bus.resp_valid = resp_valid;
    assign bus.resp_data  = res;
    assign bus.resp_id    = id;

    if (SBOX_LAT == 0) begin : g_comb
        assign cap_v = fed_v;
        assign cap_i = cnt;
    end else begin : g_pipe
        logic [SBOX_LAT-1:0]      pv;
        logic [SBOX_LAT-1:0][1:0] pix;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                pv  <= '0;
                pix <= '0;
            end else begin
                pv[0]  <= fed_v;
                pix[0] <= cnt;
                for (int j = 1; j < SBOX_LAT; j++) begin
                    pv[j]  <= pv[j-1];
                    pix[j] <= pix[j-1];
                end
            end
        end

        assign cap_v = pv[SBOX_LAT-1];
        assign cap_i = pix[SBOX_LAT-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            rr         <= 1'b1;
            id         <= 1'b0;
            cnt        <= 2'd0;
            rest       <= '0;
            res        <= '0;
            resp_valid <= 1'b0;
            sbox_in    <= 8'h00;
            busy       <= 1'b0;
        end else begin
            if (cap_v) begin
                res[cap_i] <= sbox_out;
            end
            unique case (state)
                IDLE: begin
                    if (acc0 | acc1) begin
                        id      <= acc1;
                        rr      <= acc1;
                        sbox_in <= sel_data[7:0];
                        rest    <= sel_data[31:8];
                        cnt     <= 2'd0;
                        busy    <= 1'b1;
                        state   <= FEED;
                    end
                end
                FEED: begin
                    cnt     <= cnt + 2'd1;
                    sbox_in <= rest[7:0];
                    rest    <= {8'h00, rest[23:8]};
                    if (cnt == 2'd3) begin
                        sbox_in <= 8'h00;
                        if (SBOX_LAT == 0) begin
                            resp_valid <= 1'b1;
                            state      <= RESP;
                        end else begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (cap_v && cap_i == 2'd3) begin
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        resp_valid <= 1'b0;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_inv_sbox_word_sched.sv
// Bench for inv_sbox_word_sched: three instances (SBOX_LAT 1, 0, 3)
// against an inverse S-box derived from GF(2^8) arithmetic.
module tb_inv_sbox_word_sched;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [2:0]       r0v, r1v, rrdy;
    logic [2:0][31:0] r0d, r1d;
    logic [2:0]       o_r0rdy, o_r1rdy, o_rv, o_rid, o_busy;
    logic [2:0][31:0] o_rdata;
    logic [2:0][7:0]  o_sin;
    logic [7:0]       isb [256];
    int               cyc = 0;
    int               n_checks = 0;
    int               n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : u
        localparam int L = (g == 0) ? 1 : ((g == 1) ? 0 : 3);
        inv_sbox_word_sched_if bus ();
        logic [7:0]      sin;
        logic [7:0]      sout;
        logic            bsy;
        logic [3:0][7:0] dq;

        // External S-box: table lookup delayed by L cycles.
        always @(posedge clk) dq <= {dq[2:0], sin};
        assign sout = isb[(L == 0) ? sin : dq[(L == 0) ? 0 : L - 1]];

        assign bus.req0_valid = r0v[g];
        assign bus.req0_data  = r0d[g];
        assign bus.req1_valid = r1v[g];
        assign bus.req1_data  = r1d[g];
        assign bus.resp_ready = rrdy[g];
        assign o_r0rdy[g]     = bus.req0_ready;
        assign o_r1rdy[g]     = bus.req1_ready;
        assign o_rv[g]        = bus.resp_valid;
        assign o_rdata[g]     = bus.resp_data;
        assign o_rid[g]       = bus.resp_id;
        assign o_sin[g]       = sin;
        assign o_busy[g]      = bsy;

        inv_sbox_word_sched #(.SBOX_LAT(L)) dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .bus      (bus.slave),
            .sbox_in  (sin),
            .sbox_out (sout),
            .busy     (bsy)
        );
    end

    function automatic int lat_of(input int i);
        return (i == 0) ? 1 : ((i == 1) ? 0 : 3);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] fwd_sbox(input logic [7:0] v);
        logic [7:0] b;
        b = 8'h00;
        for (int y = 1; y < 256; y++)
            if (gmul(v, 8'(y)) == 8'h01) b = 8'(y);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] inv_word(input logic [31:0] w);
        return {isb[w[31:24]], isb[w[23:16]], isb[w[15:8]], isb[w[7:0]]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        r0v   = '0;
        r1v   = '0;
        rrdy  = '1;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic do_word(input int i, input logic rid_in, input logic [31:0] d,
                           output logic [31:0] rd, output logic rid,
                           output int lat, output logic [39:0] seq);
        int acc;
        bit done;
        acc  = -1;
        done = 0;
        rd   = 32'h0;
        rid  = 1'b0;
        lat  = -1;
        seq  = '1;
        rrdy[i] = 1'b1;
        if (rid_in) begin r1v[i] = 1'b1; r1d[i] = d; end
        else begin r0v[i] = 1'b1; r0d[i] = d; end
        for (int k = 0; k < 20 && acc < 0; k++) begin
            @(negedge clk);
            if (rid_in ? o_r1rdy[i] : o_r0rdy[i]) acc = cyc + 1;
            tick();
        end
        r0v[i] = 1'b0;
        r1v[i] = 1'b0;
        for (int k = 0; k < 40 && acc >= 0 && !done; k++) begin
            @(negedge clk);
            if (k < 5) seq[8*k +: 8] = o_sin[i];
            if (o_rv[i]) begin
                rd   = o_rdata[i];
                rid  = o_rid[i];
                lat  = cyc - acc;
                done = 1;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if ({o_rv[i], o_rid[i], o_busy[i], o_r0rdy[i], o_r1rdy[i]} !== 5'b0 ||
                o_rdata[i] !== 32'h0 || o_sin[i] !== 8'h00) begin
                n_fail++;
                $display("FAIL reset_state[%0d]: got rv=%b id=%b busy=%b data=%h sin=%h expected all zero",
                         i, o_rv[i], o_rid[i], o_busy[i], o_rdata[i], o_sin[i]);
            end
        end
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        logic [31:0] rd;
        logic        rid;
        int          lat;
        logic [39:0] seq;
        do_word(0, 1'b0, 32'h0000_0000, rd, rid, lat, seq);
        n_checks++;
        if (rd !== 32'h5252_5252 || rid !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_word: got %h id %b expected 52525252 id 0", rd, rid);
        end
        n_checks++;
        if (lat !== 5) begin
            n_fail++;
            $display("FAIL zero_latency: got %0d expected 5", lat);
        end
        do_word(0, 1'b1, 32'h637C_777B, rd, rid, lat, seq);
        n_checks++;
        if (rd !== 32'h0001_0203 || rid !== 1'b1) begin
            n_fail++;
            $display("FAIL req1_word: got %h id %b expected 00010203 id 1", rd, rid);
        end
        n_checks++;
        if (seq !== 40'h00_63_7C_77_7B) begin
            n_fail++;
            $display("FAIL sbox_in_seq: got %h expected 00637c777b", seq);
        end
        n_checks++;
        if (lat !== 5) begin
            n_fail++;
            $display("FAIL req1_latency: got %0d expected 5", lat);
        end
    endtask

    task automatic test_alternate();
        int          grants[$];
        logic [31:0] qd[$];
        logic        qi[$];
        int          got;
        logic        hs0, hs1;
        got = 0;
        apply_reset();
        r0d[0] = $urandom;
        r1d[0] = $urandom;
        r0v[0] = 1'b1;
        r1v[0] = 1'b1;
        for (int k = 0; k < 200 && got < 4; k++) begin
            @(negedge clk);
            hs0 = o_r0rdy[0];
            hs1 = o_r1rdy[0];
            n_checks++;
            if (hs0 && hs1) begin
                n_fail++;
                $display("FAIL alt_two_ready: got both ready expected at most one");
            end
            if (hs0) begin grants.push_back(0); qd.push_back(inv_word(r0d[0])); qi.push_back(1'b0); end
            if (hs1) begin grants.push_back(1); qd.push_back(inv_word(r1d[0])); qi.push_back(1'b1); end
            if (o_rv[0]) begin
                n_checks++;
                if (qd.size() == 0) begin
                    n_fail++;
                    $display("FAIL alt_spurious: got response %h expected none", o_rdata[0]);
                end else begin
                    if (o_rdata[0] !== qd[0] || o_rid[0] !== qi[0]) begin
                        n_fail++;
                        $display("FAIL alt_resp: got %h id %b expected %h id %b",
                                 o_rdata[0], o_rid[0], qd[0], qi[0]);
                    end
                    void'(qd.pop_front());
                    void'(qi.pop_front());
                    got++;
                end
            end
            tick();
            if (hs0) r0d[0] = $urandom;
            if (hs1) r1d[0] = $urandom;
        end
        r0v[0] = 1'b0;
        r1v[0] = 1'b0;
        n_checks++;
        if (grants.size() < 4 || got < 4) begin
            n_fail++;
            $display("FAIL alt_count: got %0d grants %0d responses expected 4", grants.size(), got);
        end
        for (int k = 0; k < 4 && k < grants.size(); k++) begin
            n_checks++;
            if (grants[k] !== k % 2) begin
                n_fail++;
                $display("FAIL alt_grant[%0d]: got %0d expected %0d", k, grants[k], k % 2);
            end
        end
    endtask

    task automatic test_stall();
        logic [31:0] d;
        logic [31:0] exp;
        bit          acc;
        bit          seen;
        acc  = 0;
        seen = 0;
        apply_reset();
        d = $urandom;
        exp = inv_word(d);
        rrdy[0] = 1'b0;
        r0d[0]  = d;
        r0v[0]  = 1'b1;
        for (int k = 0; k < 20 && !acc; k++) begin
            @(negedge clk);
            acc = o_r0rdy[0];
            tick();
        end
        r0d[0] = $urandom;
        r1d[0] = $urandom;
        r1v[0] = 1'b1;
        for (int k = 0; k < 30 && !seen; k++) begin
            @(negedge clk);
            seen = o_rv[0];
            if (!seen) tick();
        end
        n_checks++;
        if (!seen || o_rdata[0] !== exp || o_rid[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_first: got rv=%b %h id %b expected 1 %h id 0",
                     o_rv[0], o_rdata[0], o_rid[0], exp);
        end
        for (int k = 0; k < 10; k++) begin
            tick();
            @(negedge clk);
            n_checks++;
            if (o_rv[0] !== 1'b1 || o_rdata[0] !== exp || o_rid[0] !== 1'b0 ||
                o_r0rdy[0] !== 1'b0 || o_r1rdy[0] !== 1'b0 || o_busy[0] !== 1'b1) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: got rv=%b %h id %b rdy=%b%b busy=%b expected 1 %h id 0 rdy=00 busy=1",
                         k, o_rv[0], o_rdata[0], o_rid[0], o_r1rdy[0], o_r0rdy[0], o_busy[0], exp);
            end
        end
        tick();
        rrdy[0] = 1'b1;
        @(negedge clk);
        n_checks++;
        if (o_r0rdy[0] !== 1'b0 || o_r1rdy[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_release_rdy: got rdy=%b%b expected 00", o_r1rdy[0], o_r0rdy[0]);
        end
        tick();
        @(negedge clk);
        n_checks++;
        if (o_busy[0] !== 1'b0 || o_rv[0] !== 1'b0 || o_r1rdy[0] !== 1'b1 || o_r0rdy[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_idle: got busy=%b rv=%b rdy=%b%b expected busy=0 rv=0 rdy=10",
                     o_busy[0], o_rv[0], o_r1rdy[0], o_r0rdy[0]);
        end
        tick();
        r0v[0] = 1'b0;
        r1v[0] = 1'b0;
    endtask

    task automatic test_reset_midfeed();
        logic [31:0] d;
        logic [31:0] rd;
        logic        rid;
        int          lat;
        logic [39:0] seq;
        bit          acc;
        acc = 0;
        apply_reset();
        d = $urandom;
        r0d[0] = d;
        r0v[0] = 1'b1;
        for (int k = 0; k < 20 && !acc; k++) begin
            @(negedge clk);
            acc = o_r0rdy[0];
            tick();
        end
        r0v[0] = 1'b0;
        tick();
        tick();
        @(negedge clk);
        n_checks++;
        if (o_sin[0] !== d[23:16]) begin
            n_fail++;
            $display("FAIL midfeed_byte2: got %h expected %h", o_sin[0], d[23:16]);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({o_rv[0], o_rid[0], o_busy[0], o_r0rdy[0], o_r1rdy[0]} !== 5'b0 ||
            o_rdata[0] !== 32'h0 || o_sin[0] !== 8'h00) begin
            n_fail++;
            $display("FAIL midfeed_reset: got rv=%b id=%b busy=%b data=%h sin=%h expected all zero",
                     o_rv[0], o_rid[0], o_busy[0], o_rdata[0], o_sin[0]);
        end
        tick();
        rst_n = 1'b1;
        do_word(0, 1'b0, 32'hFFFF_FFFF, rd, rid, lat, seq);
        n_checks++;
        if (rd !== 32'h7D7D_7D7D || rid !== 1'b0 || lat !== 5) begin
            n_fail++;
            $display("FAIL after_reset_word: got %h id %b lat %0d expected 7d7d7d7d id 0 lat 5",
                     rd, rid, lat);
        end
    endtask

    task automatic test_random(input int i);
        logic        qi[$];
        logic [31:0] qd[$];
        int          qe[$];
        int          issued, done, lat_exp;
        bit          in_resp;
        logic [31:0] hold_d;
        logic        hold_id;
        logic        hs0, hs1;
        issued  = 0;
        done    = 0;
        in_resp = 0;
        hold_d  = 32'h0;
        hold_id = 1'b0;
        lat_exp = lat_of(i) + 4;
        apply_reset();
        for (int c = 0; c < 40000 && done < 1000; c++) begin
            if (!r0v[i] && issued < 1000 && $urandom_range(0, 1) == 1) begin
                r0v[i] = 1'b1; r0d[i] = $urandom; issued++;
            end
            if (!r1v[i] && issued < 1000 && $urandom_range(0, 1) == 1) begin
                r1v[i] = 1'b1; r1d[i] = $urandom; issued++;
            end
            rrdy[i] = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            hs0 = r0v[i] & o_r0rdy[i];
            hs1 = r1v[i] & o_r1rdy[i];
            n_checks++;
            if (o_r0rdy[i] && o_r1rdy[i]) begin
                n_fail++;
                $display("FAIL rand%0d_two_ready: got both ready expected at most one", i);
            end
            if (hs0) begin qi.push_back(1'b0); qd.push_back(inv_word(r0d[i])); qe.push_back(cyc + 1); end
            if (hs1) begin qi.push_back(1'b1); qd.push_back(inv_word(r1d[i])); qe.push_back(cyc + 1); end
            if (o_rv[i]) begin
                n_checks++;
                if (qd.size() == 0) begin
                    n_fail++;
                    $display("FAIL rand%0d_spurious: got response %h expected none", i, o_rdata[i]);
                end else if (!in_resp) begin
                    if (cyc - qe[0] !== lat_exp) begin
                        n_fail++;
                        $display("FAIL rand%0d_latency: got %0d expected %0d", i, cyc - qe[0], lat_exp);
                    end
                end else if (o_rdata[i] !== hold_d || o_rid[i] !== hold_id) begin
                    n_fail++;
                    $display("FAIL rand%0d_stable: got %h id %b expected %h id %b",
                             i, o_rdata[i], o_rid[i], hold_d, hold_id);
                end
                if (rrdy[i] && qd.size() != 0) begin
                    n_checks++;
                    if (o_rdata[i] !== qd[0] || o_rid[i] !== qi[0]) begin
                        n_fail++;
                        $display("FAIL rand%0d_data: got %h id %b expected %h id %b",
                                 i, o_rdata[i], o_rid[i], qd[0], qi[0]);
                    end
                    void'(qd.pop_front());
                    void'(qi.pop_front());
                    void'(qe.pop_front());
                    done++;
                    in_resp = 0;
                end else begin
                    in_resp = 1;
                    hold_d  = o_rdata[i];
                    hold_id = o_rid[i];
                end
            end else if (in_resp) begin
                n_checks++;
                n_fail++;
                $display("FAIL rand%0d_dropped: got resp_valid 0 expected 1", i);
                in_resp = 0;
            end
            tick();
            if (hs0) r0v[i] = 1'b0;
            if (hs1) r1v[i] = 1'b0;
        end
        r0v[i] = 1'b0;
        r1v[i] = 1'b0;
        n_checks++;
        if (done != 1000) begin
            n_fail++;
            $display("FAIL rand%0d_count: got %0d responses expected 1000", i, done);
        end
    endtask

    initial begin
        for (int x = 0; x < 256; x++) isb[fwd_sbox(8'(x))] = 8'(x);
        r0v   = '0;
        r1v   = '0;
        rrdy  = '1;
        r0d   = '0;
        r1d   = '0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        test_reset();
        test_single();
        test_alternate();
        test_stall();
        test_reset_midfeed();
        test_random(1);
        test_random(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
